alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Decode/issue stage feeding the ALU operand and opcode interface (a, b, is_cond, op).
- Takes a fetched RV32I instruction plus register-file read values, and selects ALU operands and operation.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so fetch and execute are decoupled at full throughput.
- Sits between the fetch/regfile read and execute in the core pipeline.

Parameters:
- XLEN, 32, datapath width; must equal `XMSB+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction bundle valid.
- in_ready  out  1  stage can accept a bundle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- in_rs1  in  XLEN  regfile value for instr[19:15].
- in_rs2  in  XLEN  regfile value for instr[24:20].
- out_valid  out  1  issued bundle valid.
- out_ready  in  1  execute accepts the bundle.
- alu_a  out  XLEN  ALU operand a.
- alu_b  out  XLEN  ALU operand b.
- alu_op  out  `ALU_OP_MSB+1  ALU operation code (`ALU_OP_* values).
- alu_is_cond  out  1  branch compare mode.
- rd  out  5  destination register.
- wb_en  out  1  result is written back (forced 0 when rd==0).
- br_imm  out  XLEN  sign-extended B/J immediate (target formed downstream).
- illegal  out  1  bundle is an unrecognised encoding.

Behaviour:
- Reset: out_valid=0, in_ready=1, skid empty, all data outputs 0.
- Latency: 1 cycle. A bundle accepted at edge N (in_valid & in_ready) appears on the outputs after edge N.
- Handshake:
  - Transfer on valid&ready.
  - Outputs hold stable while out_valid & !out_ready.
  - out_valid never drops without a transfer.
- Skid buffer:
  - Main output register plus one skid register.
  - in_ready is registered: in_ready = !skid_full.
  - Accept while the output is stalled → bundle goes to skid.
  - When the output transfers and skid is full → skid moves to output, in_ready=1 on the next cycle.
  - Simultaneous accept and transfer with skid empty → new bundle goes directly to output (throughput 1/cycle).
- Decode by opcode [6:0]:
  - OP (0110011), ADD/SUB by funct7[5]:
    - a=rs1, b=rs2, is_cond=0.
    - op from funct3: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - OP-IMM (0010011):
    - a=rs1, b=sext(I-imm), same funct3 map.
    - SUB never produced.
    - funct3=101 uses instr[30] for SRA.
    - SLLI/SRLI/SRAI with instr[25]=1 → illegal.
  - BRANCH (1100011):
    - a=rs1, b=rs2, is_cond=1, wb_en=0.
    - funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
    - 010/011 → illegal.
  - LUI: a=0, b={imm[31:12],12'b0}, ADD.
  - AUIPC: a=pc, b=U-imm, ADD.
  - JAL/JALR: a=pc, b=4, ADD, wb_en per rd.
  - LOAD: a=rs1, b=I-imm, ADD, wb_en.
  - STORE: a=rs1, b=S-imm, ADD, wb_en=0.
  - Other opcodes → illegal=1, wb_en=0, alu_op=ADD, a=b=0.
- Reset mid-operation: both registers are emptied at once and the bundles in flight are discarded.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined:
  - Extra inputs fwd_valid (1), fwd_rd (5), fwd_data (XLEN).
  - When fwd_valid and fwd_rd!=0 matches instr rs1/rs2, fwd_data replaces in_rs1/in_rs2 at capture, including for bundles entering the skid.
  - The skid copy is also patched if its source register matches a fwd write that occurs while it waits.
- Undefined:
  - Ports absent; operands come only from in_rs1/in_rs2.

Decomposition:
- Constants live in defs.v: `XMSB, `ALU_OP_MSB, `ALU_OP_* codes, new `OPC_* 7-bit opcode constants and `BR_F3_* codes.
- One sub-module: alu_issue_decode, purely combinational; instruction/pc/rs values → bundle.
- alu_issue holds the handshake and skid state.

Test Plan:
- Reset: rst=1 for 2 cycles → out_valid=0, in_ready=1; release, instr 0x00B50533 (add x10,x10,x11), rs1=5, rs2=7 → next cycle a=5, b=7, op=ADD, rd=10, wb_en=1.
- 0x40B50533 (sub) → op=SUB; 0x4025D593 (srai x11,x11,2) → op=SRA, b=2; 0x0225D593 → illegal=1.
- 0x00B50463 (beq) rs1=rs2=3 → is_cond=1, op=EQ, wb_en=0, br_imm=8; funct3=010 branch → illegal=1.
- Back-pressure: stream 4 bundles with out_ready=0 for 3 cycles → skid fills, in_ready=0, no loss or reorder; release → 4 bundles out in order on consecutive cycles.
- 0x12345037 (lui x0) → a=0, b=0x12345000, wb_en=0; auipc at pc=0x100 → a=0x100; rst asserted with skid full → out_valid=0 next cycle.
- ALU_ISSUE_FWD_EN: fwd_valid, fwd_rd=10, fwd_data=0x55 with add reading x10 → a=0x55.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: widths, ALU operation codes, RV32I opcodes and decode helpers shared by the issue stage.
package alu_issue_pkg;
    localparam int XMSB = 31;
    localparam int XW = XMSB + 1;
    localparam int ALU_OP_MSB = 3;
    typedef logic [ALU_OP_MSB:0] alu_op_t;
    localparam alu_op_t ALU_OP_ADD  = 4'd0;
    localparam alu_op_t ALU_OP_SUB  = 4'd1;
    localparam alu_op_t ALU_OP_SLL  = 4'd2;
    localparam alu_op_t ALU_OP_SLT  = 4'd3;
    localparam alu_op_t ALU_OP_SLTU = 4'd4;
    localparam alu_op_t ALU_OP_XOR  = 4'd5;
    localparam alu_op_t ALU_OP_SRL  = 4'd6;
    localparam alu_op_t ALU_OP_SRA  = 4'd7;
    localparam alu_op_t ALU_OP_OR   = 4'd8;
    localparam alu_op_t ALU_OP_AND  = 4'd9;
    localparam alu_op_t ALU_OP_EQ   = 4'd10;
    localparam alu_op_t ALU_OP_NE   = 4'd11;
    localparam alu_op_t ALU_OP_LT   = 4'd12;
    localparam alu_op_t ALU_OP_GE   = 4'd13;
    localparam alu_op_t ALU_OP_LTU  = 4'd14;
    localparam alu_op_t ALU_OP_GEU  = 4'd15;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [2:0] BR_F3_EQ  = 3'b000;
    localparam logic [2:0] BR_F3_NE  = 3'b001;
    localparam logic [2:0] BR_F3_LT  = 3'b100;
    localparam logic [2:0] BR_F3_GE  = 3'b101;
    localparam logic [2:0] BR_F3_LTU = 3'b110;
    localparam logic [2:0] BR_F3_GEU = 3'b111;
    typedef struct packed {
        logic [XMSB:0] a;
        logic [XMSB:0] b;
        alu_op_t       op;
        logic          is_cond;
        logic [4:0]    rd;
        logic          wb_en;
        logic [XMSB:0] br_imm;
        logic          illegal;
    } bundle_t;
    // Which operands of a captured bundle came straight from the register file.
    typedef struct packed {
        logic       a_rs1;
        logic       b_rs2;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } src_t;
    function automatic alu_op_t alu_f3(logic [2:0] f3, logic alt);
        case (f3)
            3'b000: alu_f3 = alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001: alu_f3 = ALU_OP_SLL;
            3'b010: alu_f3 = ALU_OP_SLT;
            3'b011: alu_f3 = ALU_OP_SLTU;
            3'b100: alu_f3 = ALU_OP_XOR;
            3'b101: alu_f3 = alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110: alu_f3 = ALU_OP_OR;
            3'b111: alu_f3 = ALU_OP_AND;
        endcase
    endfunction
    function automatic alu_op_t br_op(logic [2:0] f3);
        return f3 == BR_F3_EQ ? ALU_OP_EQ : f3 == BR_F3_NE ? ALU_OP_NE :
               f3 == BR_F3_LT ? ALU_OP_LT : f3 == BR_F3_GE ? ALU_OP_GE :
               f3 == BR_F3_LTU ? ALU_OP_LTU : ALU_OP_GEU;
    endfunction
    function automatic src_t src_of(logic [31:0] instr);
        src_t s;
        s.rs1 = instr[19:15];
        s.rs2 = instr[24:20];
        s.a_rs1 = instr[6:0] inside {OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_LOAD, OPC_STORE};
        s.b_rs2 = instr[6:0] inside {OPC_OP, OPC_BRANCH};
        return s;
    endfunction
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I decode of instruction, pc and register values into an ALU bundle.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] a_o,
    output logic [XLEN-1:0] b_o,
    output alu_op_t         op_o,
    output logic            is_cond_o,
    output logic [4:0]      rd_o,
    output logic            wb_en_o,
    output logic [XLEN-1:0] br_imm_o,
    output logic            illegal_o
);
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            shift, wr;
    logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign shift = f3[1:0] == 2'b01;
    assign rd_o  = instr_i[11:7];
    assign i_imm = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign s_imm = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign b_imm = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign u_imm = {instr_i[31:12], 12'b0};
    assign j_imm = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign br_imm_o = opc == OPC_JAL ? j_imm : b_imm;
    assign wb_en_o  = wr && rd_o != 5'd0;
    always_comb begin
        a_o = '0;
        b_o = '0;
        op_o = ALU_OP_ADD;
        is_cond_o = 1'b0;
        wr = 1'b0;
        illegal_o = 1'b0;
        case (opc)
            OPC_OP: begin
                a_o = rs1_i;
                b_o = rs2_i;
                op_o = alu_f3(f3, instr_i[30]);
                wr = 1'b1;
            end
            OPC_OPIMM: begin
                // Immediate shifts take only a 5-bit shamt; instr[25] set is an RV64 encoding.
                if (shift && instr_i[25]) illegal_o = 1'b1;
                else begin
                    a_o = rs1_i;
                    b_o = shift ? {{(XLEN-5){1'b0}}, instr_i[24:20]} : i_imm;
                    op_o = alu_f3(f3, f3 == 3'b101 && instr_i[30]);
                    wr = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (f3[2:1] == 2'b01) illegal_o = 1'b1;
                else begin
                    a_o = rs1_i;
                    b_o = rs2_i;
                    op_o = br_op(f3);
                    is_cond_o = 1'b1;
                end
            end
            OPC_LUI: begin
                b_o = u_imm;
                wr = 1'b1;
            end
            OPC_AUIPC: begin
                a_o = pc_i;
                b_o = u_imm;
                wr = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                a_o = pc_i;
                b_o = XLEN'(4);
                wr = 1'b1;
            end
            OPC_LOAD: begin
                a_o = rs1_i;
                b_o = i_imm;
                wr = 1'b1;
            end
            OPC_STORE: begin
                a_o = rs1_i;
                b_o = s_imm;
            end
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue stage with a registered valid/ready output and a one-entry skid register.
// Optional ALU_ISSUE_FWD_EN adds a writeback forwarding port that patches operands at capture and in the skid.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [ALU_OP_MSB:0] alu_op,
    output logic            alu_is_cond,
    output logic [4:0]      rd,
    output logic            wb_en,
    output logic [XLEN-1:0] br_imm,
    output logic            illegal
`ifdef ALU_ISSUE_FWD_EN
    ,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data
`endif
);
    bundle_t         out_q, out_d, skid_q, skid_d, dec;
    logic            out_valid_q, out_valid_d, skid_full_q, skid_full_d;
    logic            acc, xfer;
    logic [XLEN-1:0] rs1_v, rs2_v, d_a, d_b, d_br_imm;
    alu_op_t         d_op;
    logic            d_cond, d_wb, d_ill;
    logic [4:0]      d_rd;
`ifdef ALU_ISSUE_FWD_EN
    logic            fwd_hit;
    src_t            src_q, src_d;
    assign fwd_hit = fwd_valid && fwd_rd != 5'd0;
    assign rs1_v = fwd_hit && fwd_rd == in_instr[19:15] ? fwd_data : in_rs1;
    assign rs2_v = fwd_hit && fwd_rd == in_instr[24:20] ? fwd_data : in_rs2;
`else
    assign rs1_v = in_rs1;
    assign rs2_v = in_rs2;
`endif
    alu_issue_decode #(.XLEN(XLEN)) u_dec (
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .rs1_i    (rs1_v),
        .rs2_i    (rs2_v),
        .a_o      (d_a),
        .b_o      (d_b),
        .op_o     (d_op),
        .is_cond_o(d_cond),
        .rd_o     (d_rd),
        .wb_en_o  (d_wb),
        .br_imm_o (d_br_imm),
        .illegal_o(d_ill)
    );
    assign dec  = {d_a, d_b, d_op, d_cond, d_rd, d_wb, d_br_imm, d_ill};
    assign acc  = in_valid && !skid_full_q;
    assign xfer = out_valid_q && out_ready;
    always_comb begin
        out_d = out_q;
        skid_d = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
`ifdef ALU_ISSUE_FWD_EN
        src_d = src_q;
        if (fwd_hit && !skid_q.illegal && src_q.a_rs1 && src_q.rs1 == fwd_rd) skid_d.a = fwd_data;
        if (fwd_hit && !skid_q.illegal && src_q.b_rs2 && src_q.rs2 == fwd_rd) skid_d.b = fwd_data;
`endif
        // in_ready is low while the skid is full, so no accept can race the skid drain.
        if (skid_full_q) begin
            if (xfer) begin
                out_d = skid_d;
                skid_full_d = 1'b0;
            end
        end else if (acc) begin
            if (!out_valid_q || xfer) begin
                out_d = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d = dec;
                skid_full_d = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
                src_d = src_of(in_instr);
`endif
            end
        end else if (xfer) out_valid_d = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            skid_q <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q <= out_d;
            skid_q <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
        end
    end
`ifdef ALU_ISSUE_FWD_EN
    always_ff @(posedge clk) src_q <= rst ? '0 : src_d;
`endif
    assign in_ready    = !skid_full_q;
    assign out_valid   = out_valid_q;
    assign alu_a       = out_q.a;
    assign alu_b       = out_q.b;
    assign alu_op      = out_q.op;
    assign alu_is_cond = out_q.is_cond;
    assign rd          = out_q.rd;
    assign wb_en       = out_q.wb_en;
    assign br_imm      = out_q.br_imm;
    assign illegal     = out_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random stimulus against a queue-based reference of the issue stage.
module tb_alu_issue;
    import alu_issue_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0, in_rs1 = '0, in_rs2 = '0;
    logic        in_ready, out_valid, alu_is_cond, wb_en, illegal;
    logic [31:0] alu_a, alu_b, br_imm;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_rd = '0;
    logic [31:0] fwd_data = '0;
`endif
    alu_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_is_cond(alu_is_cond), .rd(rd), .wb_en(wb_en),
        .br_imm(br_imm), .illegal(illegal)
`ifdef ALU_ISSUE_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] a, b, bimm;
        logic [3:0]  op;
        logic        cond, wb, ill, u1, u2;
        logic [4:0]  rd, s1, s2;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    alu_op_t alu_tbl[8] = '{ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_XOR, ALU_OP_SRL, ALU_OP_OR, ALU_OP_AND};
    alu_op_t br_tbl[8] = '{ALU_OP_EQ, ALU_OP_NE, ALU_OP_ADD, ALU_OP_ADD, ALU_OP_LT, ALU_OP_GE, ALU_OP_LTU, ALU_OP_GEU};
    logic [6:0] opcs[9] = '{OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE};
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Expected bundle from the ISA rules, immediates built arithmetically from the word.
    function automatic exp_t model(input logic [31:0] ins, pc, r1, r2);
        exp_t e;
        logic [6:0]  opc = ins[6:0];
        int          f3 = int'(ins[14:12]);
        logic        shift = f3 == 1 || f3 == 5;
        logic [31:0] iimm = 32'($signed(ins) >>> 20);
        logic [31:0] simm = (iimm & 32'hffffffe0) | 32'(ins[11:7]);
        logic [31:0] bimm = (ins[31] ? 32'hfffff000 : 32'h0) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        logic [31:0] jimm = (ins[31] ? 32'hfff00000 : 32'h0) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        logic [31:0] uimm = ins & 32'hfffff000;
        e = '{a: 0, b: 0, bimm: 0, op: ALU_OP_ADD, cond: 0, wb: 0, ill: 1, u1: 0, u2: 0, rd: ins[11:7], s1: ins[19:15], s2: ins[24:20]};
        e.bimm = opc == OPC_JAL ? jimm : bimm;
        case (opc)
            OPC_OP: begin
                e.ill = 0; e.a = r1; e.b = r2; e.u1 = 1; e.u2 = 1; e.wb = 1;
                e.op = ins[30] && f3 == 0 ? ALU_OP_SUB : ins[30] && f3 == 5 ? ALU_OP_SRA : alu_tbl[f3];
            end
            OPC_OPIMM: if (!(shift && ins[25])) begin
                e.ill = 0; e.a = r1; e.u1 = 1; e.wb = 1;
                e.b = shift ? 32'(ins[24:20]) : iimm;
                e.op = ins[30] && f3 == 5 ? ALU_OP_SRA : alu_tbl[f3];
            end
            OPC_BRANCH: if (f3 != 2 && f3 != 3) begin
                e.ill = 0; e.a = r1; e.b = r2; e.u1 = 1; e.u2 = 1; e.cond = 1; e.op = br_tbl[f3];
            end
            OPC_LUI:   begin e.ill = 0; e.b = uimm; e.wb = 1; end
            OPC_AUIPC: begin e.ill = 0; e.a = pc; e.b = uimm; e.wb = 1; end
            OPC_JAL, OPC_JALR: begin e.ill = 0; e.a = pc; e.b = 4; e.wb = 1; end
            OPC_LOAD:  begin e.ill = 0; e.a = r1; e.b = iimm; e.u1 = 1; e.wb = 1; end
            OPC_STORE: begin e.ill = 0; e.a = r1; e.b = simm; e.u1 = 1; end
            default: ;
        endcase
        e.wb = e.wb && e.rd != 0;
        return e;
    endfunction
    task automatic check_head(input exp_t e);
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("alu_op", alu_op, e.op);
        check("alu_is_cond", alu_is_cond, e.cond);
        check("rd", rd, e.rd);
        check("wb_en", wb_en, e.wb);
        check("br_imm", br_imm, e.bimm);
        check("illegal", illegal, e.ill);
    endtask
    // One cycle: drive inputs, compare against the in-flight queue, then advance it past the edge.
    task automatic step(input logic v, input logic [31:0] ins, pc, r1, r2, input logic rdy, output logic acc);
        exp_t        nb, t;
        logic        xfer;
        logic [31:0] e1 = r1, e2 = r2;
        in_valid = v; in_instr = ins; in_pc = pc; in_rs1 = r1; in_rs2 = r2; out_ready = rdy;
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) check_head(q[0]);
        acc = v && q.size() < 2;
        xfer = q.size() > 0 && rdy;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_valid && fwd_rd != 0) begin
            if (fwd_rd == ins[19:15]) e1 = fwd_data;
            if (fwd_rd == ins[24:20]) e2 = fwd_data;
            if (q.size() == 2) begin
                t = q[1];
                if (t.u1 && t.s1 == fwd_rd) t.a = fwd_data;
                if (t.u2 && t.s2 == fwd_rd) t.b = fwd_data;
                q[1] = t;
            end
        end
`endif
        nb = model(ins, pc, e1, e2);
        @(posedge clk);
        #1;
        if (xfer) void'(q.pop_front());
        if (acc) q.push_back(nb);
    endtask
    logic [31:0] bp[4] = '{32'h00B50533, 32'h40C686B3, 32'h00F77733, 32'h0117E7B3};
    initial begin
        logic [31:0] ins;
        logic        ok;
        int          k, cyc, sel;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0;
        step(1, 32'h00B50533, 0, 5, 7, 1, ok);
        check("add_a", alu_a, 5);
        check("add_b", alu_b, 7);
        check("add_op", alu_op, ALU_OP_ADD);
        check("add_rd", rd, 10);
        check("add_wb", wb_en, 1);
        step(1, 32'h40B50533, 0, 9, 4, 1, ok);
        check("sub_op", alu_op, ALU_OP_SUB);
        step(1, 32'h4025D593, 0, 32'h80000000, 0, 1, ok);
        check("srai_op", alu_op, ALU_OP_SRA);
        check("srai_b", alu_b, 2);
        step(1, 32'h0225D593, 0, 1, 1, 1, ok);
        check("srai25_illegal", illegal, 1);
        step(1, 32'h00B50463, 0, 3, 3, 1, ok);
        check("beq_cond", alu_is_cond, 1);
        check("beq_op", alu_op, ALU_OP_EQ);
        check("beq_wb", wb_en, 0);
        check("beq_imm", br_imm, 8);
        step(1, 32'h00B52463, 0, 3, 3, 1, ok);
        check("br010_illegal", illegal, 1);
        step(1, 32'h12345037, 0, 1, 2, 1, ok);
        check("lui_a", alu_a, 0);
        check("lui_b", alu_b, 32'h12345000);
        check("lui_wb", wb_en, 0);
        step(1, 32'h00000517, 32'h100, 1, 2, 1, ok);
        check("auipc_a", alu_a, 32'h100);
        step(0, 0, 0, 0, 0, 1, ok);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 50) begin
            step(1, bp[k], 32'h200 + 32'(k * 4), 32'(k + 1), 32'(k + 11), cyc >= 3, ok);
            if (cyc == 1) check("bp_in_ready", in_ready, 0);
            if (ok) k++;
            cyc++;
        end
        check("bp_accepted", k, 4);
        repeat (3) step(0, 0, 0, 0, 0, 1, ok);
        step(1, bp[0], 0, 1, 2, 0, ok);
        step(1, bp[1], 0, 3, 4, 0, ok);
        check("rstfull_in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        check("rstfull_out_valid", out_valid, 0);
        check("rstfull_in_ready1", in_ready, 1);
`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b1; fwd_rd = 10; fwd_data = 32'h55;
        step(1, 32'h00B50533, 0, 5, 7, 1, ok);
        check("fwd_a", alu_a, 32'h55);
        fwd_valid = 1'b0;
        step(1, 32'h003100B3, 0, 1, 2, 0, ok);
        fwd_valid = 1'b1; fwd_rd = 3; fwd_data = 32'h99;
        step(0, 0, 0, 0, 0, 0, ok);
        fwd_valid = 1'b0;
        step(0, 0, 0, 0, 0, 1, ok);
        check("fwd_skid_b", alu_b, 32'h99);
        step(0, 0, 0, 0, 0, 1, ok);
`endif
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 9) ins[6:0] = opcs[sel];
            step($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom, $urandom_range(0, 2) != 0, ok);
        end
        repeat (3) step(0, 0, 0, 0, 0, 1, ok);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
